lsu_dbus_scheduler: RTL

Sequences shared data-bus access among the `LSU_RS_SIZE` load/store functional-unit slots and the store unit. It picks one owner at a time and holds that grant until the cached or uncached dbus finishes the transaction. It applies round-robin fairness among loads, commit-order gating for uncached loads, and store-buffer pressure priority. It sits between the per-slot LSUs/store unit and the `dbus`/`dbus_uncached` masters; its owner select drives the request/response muxes.

---
 rtl/cpu_defs.sv | 30 +++
 rtl/lsu_dbus_scheduler_pkg.sv | 15 +
 rtl/lsu_dbus_scheduler_if.sv | 45 ++++
 rtl/lsu_dbus_scheduler_rr_pick.sv | 36 +++
 rtl/lsu_dbus_scheduler.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// cpu_defs: CPU-wide shared types used by the LSU data-bus scheduler.
//   rob_index_t     - reorder-buffer index
//   lsu_owner_t     - latched data-bus owner (slot index, bus select, store flag, valid)
//   sched_state_t   - scheduler FSM state encoding
// Also provides a default for `LSU_RS_SIZE when the build does not set one.

`ifndef LSU_RS_SIZE
`define LSU_RS_SIZE 4
`endif

package cpu_defs;

    localparam int ROB_IDX_W   = 6;
    localparam int OWNER_IDX_W = 8;

    typedef logic [ROB_IDX_W-1:0] rob_index_t;

    typedef struct packed {
        logic [OWNER_IDX_W-1:0] idx;
        logic                   uncached;
        logic                   is_store;
        logic                   valid;
    } lsu_owner_t;

    typedef enum logic {
        SCHED_IDLE = 1'b0,
        SCHED_BUSY = 1'b1
    } sched_state_t;

endpackage

// File: rtl/lsu_dbus_scheduler_pkg.sv
// lsu_dbus_scheduler_pkg: local constants and helpers for the data-bus scheduler.
//   AGE_LIMIT_DEFAULT - default store starvation threshold (lost arbitrations)
//   rr_next()         - round-robin pointer advance, wrapping at n

package lsu_dbus_scheduler_pkg;

    import cpu_defs::*;

    localparam int AGE_LIMIT_DEFAULT = 8;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/lsu_dbus_scheduler_if.sv
// lsu_dbus_scheduler_if: request/grant bundle between the LSU slots, the store
// unit, the dbus stall sources and the scheduler.
//   slave  modport - scheduler side (requests/stalls in, grants/owner out)
//   master modport - requester side (requests/stalls out, grants/owner in)

`ifndef LSU_RS_SIZE
`define LSU_RS_SIZE 4
`endif

interface lsu_dbus_scheduler_if
    import cpu_defs::*;
#(
    parameter int N_REQ = `LSU_RS_SIZE
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic                   flush;
    logic [N_REQ-1:0]       ld_req;
    logic [N_REQ-1:0]       ld_uncached;
    rob_index_t             ld_reorder [N_REQ];
    rob_index_t             rob_head;
    logic                   st_req;
    logic                   st_uncached;
    logic                   st_full;
    logic                   dbus_stall;
    logic                   dbus_uncached_stall;
    logic [N_REQ-1:0]       ld_grant;
    logic                   st_grant;
    logic [IDX_W-1:0]       owner_idx;
    logic                   owner_uncached;
    logic                   owner_is_store;

    modport slave (
        input  flush, ld_req, ld_uncached, ld_reorder, rob_head,
               st_req, st_uncached, st_full, dbus_stall, dbus_uncached_stall,
        output ld_grant, st_grant, owner_idx, owner_uncached, owner_is_store
    );

    modport master (
        output flush, ld_req, ld_uncached, ld_reorder, rob_head,
               st_req, st_uncached, st_full, dbus_stall, dbus_uncached_stall,
        input  ld_grant, st_grant, owner_idx, owner_uncached, owner_is_store
    );

endinterface

// File: rtl/lsu_dbus_scheduler_rr_pick.sv
// lsu_dbus_scheduler_rr_pick: combinational round-robin priority encoder.
//   req_i    - request vector
//   ptr_i    - highest-priority position; scan proceeds upward, wrapping
//   onehot_o - winner as a one-hot vector
//   idx_o    - winner index (0 when none)
//   found_o  - any request present

module lsu_dbus_scheduler_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    int slot;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found_o  = 1'b0;
        slot     = 0;
        for (int k = 0; k < N; k++) begin
            slot = (int'(ptr_i) + k) % N;
            if (!found_o && req_i[slot]) begin
                found_o        = 1'b1;
                onehot_o[slot] = 1'b1;
                idx_o          = IDX_W'(slot);
            end
        end
    end

endmodule

// File: rtl/lsu_dbus_scheduler.sv
// lsu_dbus_scheduler: grants the shared data bus to one LSU load slot or the
// store unit at a time and holds the grant until the selected bus (cached or
// uncached) stops stalling.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - lsu_dbus_scheduler_if.slave: requests, ROB ordering, stalls
//                in; registered grants and owner select out
// Build option: LSU_STORE_AGING_EN adds a store age counter that forces a
// store win after AGE_LIMIT lost arbitrations. Without it the store preempts
// loads only when the store buffer is full.
//
// state      | meaning
// SCHED_IDLE | no owner; arbitrate every cycle
// SCHED_BUSY | owner latched; arbitrate again only in its completion cycle

module lsu_dbus_scheduler
    import cpu_defs::*;
    import lsu_dbus_scheduler_pkg::*;
#(
    parameter int N_REQ     = `LSU_RS_SIZE,
    parameter int AGE_LIMIT = AGE_LIMIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lsu_dbus_scheduler_if.slave  bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    sched_state_t     state_q, state_d;
    lsu_owner_t       owner_q, owner_d;
    logic [N_REQ-1:0] ld_grant_q, ld_grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             owner_stall, complete, arb_en;
    logic [N_REQ-1:0] ld_elig, pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             st_elig, st_prio, st_win;

    assign owner_stall = owner_q.uncached ? bus.dbus_uncached_stall : bus.dbus_stall;
    assign complete    = (state_q == SCHED_BUSY) && !owner_stall;
    assign arb_en      = (state_q == SCHED_IDLE) || complete;

    // The completing owner still has its request raised this cycle, so it is
    // masked out; otherwise it would be granted the same transaction twice.
    always_comb begin
        ld_elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ld_elig[i] = bus.ld_req[i]
                      && (!bus.ld_uncached[i] || (bus.ld_reorder[i] == bus.rob_head))
                      && !bus.flush
                      && !(complete && !owner_q.is_store && (owner_q.idx == OWNER_IDX_W'(i)));
        end
    end

    assign st_elig = bus.st_req && !(complete && owner_q.is_store);

    lsu_dbus_scheduler_rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i    (ld_elig),
        .ptr_i    (rr_ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .found_o  (pick_found)
    );

`ifdef LSU_STORE_AGING_EN
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);

    logic [AGE_W-1:0] age_q, age_d;

    assign st_prio = st_elig && (bus.st_full || (age_q >= AGE_W'(AGE_LIMIT)));

    always_comb begin
        age_d = age_q;
        if (!bus.st_req || st_win) begin
            age_d = '0;
        end else if (arb_en && (age_q < AGE_W'(AGE_LIMIT))) begin
            age_d = age_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    assign st_prio = st_elig && bus.st_full;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ld_grant_d = ld_grant_q;
        rr_ptr_d   = rr_ptr_q;
        st_win     = 1'b0;
        if (arb_en) begin
            state_d    = SCHED_IDLE;
            owner_d    = '0;
            ld_grant_d = '0;
            if (st_prio) begin
                st_win = 1'b1;
            end else if (pick_found) begin
                state_d          = SCHED_BUSY;
                owner_d.valid    = 1'b1;
                owner_d.idx      = OWNER_IDX_W'(pick_idx);
                owner_d.uncached = bus.ld_uncached[pick_idx];
                ld_grant_d       = pick_onehot;
                rr_ptr_d         = IDX_W'(rr_next(int'(pick_idx), N_REQ));
            end else if (st_elig) begin
                st_win = 1'b1;
            end
            if (st_win) begin
                state_d          = SCHED_BUSY;
                owner_d.valid    = 1'b1;
                owner_d.is_store = 1'b1;
                owner_d.uncached = bus.st_uncached;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SCHED_IDLE;
            owner_q    <= '0;
            ld_grant_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ld_grant_q <= ld_grant_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign bus.ld_grant       = ld_grant_q;
    assign bus.st_grant       = owner_q.valid && owner_q.is_store;
    assign bus.owner_idx      = owner_q.idx[IDX_W-1:0];
    assign bus.owner_uncached = owner_q.uncached;
    assign bus.owner_is_store = owner_q.is_store;

endmodule
